rr_mux: RTL

RR_MUX -- requirements
Module: rr_mux

---
 rtl/rr_mux_pkg.sv | 12 +
 rtl/rr_mux_pick.sv | 29 ++
 rtl/rr_mux.sv | 82 ++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared defaults and mode encoding for the round-robin output mux.
package rr_mux_pkg;

  localparam int DEF_W = 32;
  localparam int DEF_N = 4;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_mux_pick.sv
// Round-robin search: first requesting channel starting at ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          any
);

  always_comb begin
    int          idx;
    logic [SW-1:0] idx_s;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    idx_s = '0;
    for (int k = 0; k < N; k++) begin
      idx   = (int'(ptr) + k) % N;
      idx_s = SW'(idx);
      if (!any && req[idx_s]) begin
        grant = idx_s;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel mux with a single registered output stage; channel chosen by sel
// (fixed mode) or by a round-robin pointer that advances past each grant.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int N  = DEF_N,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_grant;
  logic          rr_any;
  logic          sel_ok;
  logic          eligible;
  logic          load;
  logic [SW-1:0] g;
  logic [W-1:0]  ch [N];

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .any   (rr_any)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch[i] = in_data[i*W +: W];
    end
  end

  // An out-of-range sel matches no channel, so nothing is eligible.
  always_comb begin
    sel_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        sel_ok = in_valid[i];
      end
    end
  end

  always_comb begin
    load     = !out_valid || out_ready;
    eligible = (mode == MODE_RR) ? rr_any : sel_ok;
    g        = (mode == MODE_RR) ? rr_grant : sel;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !reset && load && eligible && (g == SW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (eligible) begin
        out_data  <= ch[g];
        out_sel   <= g;
        out_valid <= 1'b1;
        ptr       <= (int'(g) == N-1) ? '0 : SW'(int'(g) + 1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
